ift_sram_req_adapter: RTL and testbench
=======================================

// Module: ift_sram_req_adapter
// PURPOSE
// - Upstream request adapter for the tainted SRAM (ift_sram_mem): converts a valid/ready request
//   channel with taint sidebands into the SRAM's req/write/addr/wdata/wmask strobe interface.
// - Captures the SRAM's fixed 1-cycle read data (plus taints) into a response FIFO.
// - Issues upstream requests only when response space is guaranteed (credit scheme); no data loss.
// PARAMETERS
// - Width     64  data width in bits; WidthBytes = Width/8
// - Aw        8   SRAM word-address width
// - NumTaints 1   taint vectors per signal (only 1 supported; initial assert)
// - RspDepth  2   response FIFO entries, >=2; Pw = $clog2(RspDepth+1)
// PORTS
// - clk_i              in   1              clock
// - rst_ni             in   1              asynchronous reset, active-low
// - req_valid_i        in   1              request valid
// - req_ready_o        out  1              request accepted when valid&ready
// - req_we_i           in   1              1 = write, 0 = read
// - req_addr_i         in   Aw             word address
// - req_wdata_i        in   Width          write data
// - req_be_i           in   WidthBytes     byte enables (writes)
// - req_*_taint_i      in   per field      taints of valid/we/addr/wdata/be ([NumTaints][...])
// - rsp_valid_o        out  1              response valid (one per accepted request)
// - rsp_ready_i        in   1              response consumed when valid&ready
// - rsp_rdata_o        out  Width          read data; '0 for writes
// - rsp_rdata_taint_o  out  [NumTaints][Width]  read data taint
// - sram_req_o/sram_write_o/sram_addr_o/sram_wdata_o/sram_wmask_o  out  1/1/Aw/Width/WidthBytes  SRAM strobes
// - sram_*_taint_o     out  per field      taints of the SRAM strobes
// - sram_rdata_i       in   Width          SRAM read data (cycle after sram_req_o)
// - sram_rdata_taint_i in   [NumTaints][Width]  SRAM read data taint
// BEHAVIOUR
// - acc = req_valid_i & req_ready_o; pop = rsp_valid_o & rsp_ready_i.
// - req_ready_o = (cnt_q + infl_q - pop) < RspDepth; combinational from regs and rsp_ready_i.
// - Cycle T (acc=1): sram_req_o=1, sram_write_o/addr/wdata/wmask = request fields (wmask=be).
//   Taint outputs carry the request taints; sram_req taint = req_valid taint.
//   When acc=0: all sram_* and sram_*_taint outputs are '0.
// - infl_q <= acc; registered infl_we_q <= req_we_i.
// - Cycle T+1 (infl_q=1): push {infl_we_q ? '0 : sram_rdata_i, infl_we_q ? '0 : sram_rdata_taint_i}.
// - rsp_valid_o = cnt_q != 0 (head of FIFO). Request-to-response latency is 2 cycles minimum.
// - With rsp_ready_i held at 1, 1 request/cycle is sustained.
// - FIFO: circular; rd/wr pointers wrap at RspDepth-1 -> 0. Push and pop in the same cycle: cnt unchanged.
// - Overflow is impossible by construction; overflow/underflow assertions are present under `ifndef SYNTHESIS`.
// - Responses are delivered in request order.
// - Reset (async, any time): cnt_q, infl_q, ptrs <= 0; in-flight data is dropped.
//   rsp_valid_o=0, req_ready_o=1, sram_req_o=0 while rst_ni=0 (req_ready_o=0 when RspDepth check fails).
// - FIFO payload is not reset; rsp_rdata_o/rsp_rdata_taint_o are don't-care while rsp_valid_o=0.
// CONFIGURATION
// - IFT_SRAM_ADAPTER_CTRL_TAINT_EN defined:
//   - Per request, record ctl_t = |req_valid_taint | |req_we_taint | |req_addr_taint (+ |be_taint for writes).
//   - If ctl_t, the pushed response taint is all-ones (both reads and writes).
// - Not defined: response taint = SRAM read taint (reads) or '0 (writes) only.
// TESTING
// - Reset, idle: rsp_valid_o=0, req_ready_o=1, sram_req_o=0.
// - Write 0xDEADBEEF_00000000 @0x10, be=0xFF, then read @0x10 (rsp_ready=1):
//   write rsp rdata=0 at T+2; read rsp rdata=0xDEADBEEF_00000000 at T+3.
// - rsp_ready_i=0, 3 back-to-back reads: 2 accepted, req_ready_o=0 on 3rd.
//   Release rsp_ready_i: responses arrive in order; 3rd read is accepted in the same cycle as the 1st pop.
// - Read with sram_rdata_taint_i=0x00FF: rsp_rdata_taint_o=0x00FF; addr taint bit0 set:
//   all-ones with macro, 0x00FF without.
// - Assert rst_ni=0 with 1 in flight and 1 queued: rsp_valid_o drops immediately.
//   After release: no stale response, cnt=0.
// - Continuous random reads at rsp_ready=1 for 100 cycles: 100 accepts, 100 responses, ready never low.

Source files
------------

// File: rtl/ift_sram_req_adapter.sv
// Valid/ready request adapter in front of the tainted SRAM, with a credit-managed response FIFO.
// Optional build macro IFT_SRAM_ADAPTER_CTRL_TAINT_EN: control-path taint poisons the response taint.
module ift_sram_req_adapter #(
  parameter int unsigned Width      = 64,
  parameter int unsigned Aw         = 8,
  parameter int unsigned NumTaints  = 1,
  parameter int unsigned RspDepth   = 2,
  localparam int unsigned WidthBytes = Width / 8,
  localparam int unsigned Pw         = $clog2(RspDepth + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  // Upstream request channel
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic                                 req_we_i,
  input  logic [Aw-1:0]                        req_addr_i,
  input  logic [Width-1:0]                     req_wdata_i,
  input  logic [WidthBytes-1:0]                req_be_i,
  input  logic [NumTaints-1:0]                 req_valid_taint_i,
  input  logic [NumTaints-1:0]                 req_we_taint_i,
  input  logic [NumTaints-1:0][Aw-1:0]         req_addr_taint_i,
  input  logic [NumTaints-1:0][Width-1:0]      req_wdata_taint_i,
  input  logic [NumTaints-1:0][WidthBytes-1:0] req_be_taint_i,
  // Upstream response channel
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic [Width-1:0]                     rsp_rdata_o,
  output logic [NumTaints-1:0][Width-1:0]      rsp_rdata_taint_o,
  // SRAM strobe interface
  output logic                                 sram_req_o,
  output logic                                 sram_write_o,
  output logic [Aw-1:0]                        sram_addr_o,
  output logic [Width-1:0]                     sram_wdata_o,
  output logic [WidthBytes-1:0]                sram_wmask_o,
  output logic [NumTaints-1:0]                 sram_req_taint_o,
  output logic [NumTaints-1:0]                 sram_write_taint_o,
  output logic [NumTaints-1:0][Aw-1:0]         sram_addr_taint_o,
  output logic [NumTaints-1:0][Width-1:0]      sram_wdata_taint_o,
  output logic [NumTaints-1:0][WidthBytes-1:0] sram_wmask_taint_o,
  input  logic [Width-1:0]                     sram_rdata_i,
  input  logic [NumTaints-1:0][Width-1:0]      sram_rdata_taint_i
);

  localparam int unsigned PtrW     = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned OccW     = Pw + 1;
  localparam bit          ConfigOk = (RspDepth >= 2) && (NumTaints == 1);

  logic                            acc;
  logic                            pop;
  logic                            push;
  logic [OccW-1:0]                 occ;

  logic                            infl_q;
  logic                            infl_we_q;
  logic [Pw-1:0]                   cnt_q, cnt_d;
  logic [PtrW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]                 rd_ptr_q, rd_ptr_d;

  logic [Width-1:0]                push_data;
  logic [NumTaints-1:0][Width-1:0] push_taint;
  logic [Width-1:0]                data_q  [RspDepth];
  logic [NumTaints-1:0][Width-1:0] taint_q [RspDepth];

  // Credit check: entries held plus the read in flight, less the slot freed this cycle.
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign push        = infl_q;
  assign occ         = {1'b0, cnt_q} + OccW'(infl_q) - OccW'(pop);
  assign req_ready_o = ConfigOk && (occ < OccW'(RspDepth));
  assign acc         = req_valid_i & req_ready_o;

  // SRAM strobes are driven only on the accepting cycle, zero otherwise.
  always_comb begin
    sram_req_o         = acc;
    sram_write_o       = acc & req_we_i;
    sram_addr_o        = acc ? req_addr_i        : '0;
    sram_wdata_o       = acc ? req_wdata_i       : '0;
    sram_wmask_o       = acc ? req_be_i          : '0;
    sram_req_taint_o   = acc ? req_valid_taint_i : '0;
    sram_write_taint_o = acc ? req_we_taint_i    : '0;
    sram_addr_taint_o  = acc ? req_addr_taint_i  : '0;
    sram_wdata_taint_o = acc ? req_wdata_taint_i : '0;
    sram_wmask_taint_o = acc ? req_be_taint_i    : '0;
  end

`ifdef IFT_SRAM_ADAPTER_CTRL_TAINT_EN
  logic ctl_t;
  logic infl_ctl_q;

  always_comb begin
    ctl_t = 1'b0;
    for (int unsigned t = 0; t < NumTaints; t++) begin
      ctl_t = ctl_t | req_valid_taint_i[t] | req_we_taint_i[t] | (|req_addr_taint_i[t])
            | (req_we_i & (|req_be_taint_i[t]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_ctl_q <= 1'b0;
    end else begin
      infl_ctl_q <= acc & ctl_t;
    end
  end
`endif

  always_comb begin
    push_data  = infl_we_q ? '0 : sram_rdata_i;
    push_taint = infl_we_q ? '0 : sram_rdata_taint_i;
`ifdef IFT_SRAM_ADAPTER_CTRL_TAINT_EN
    if (infl_ctl_q) begin
      push_taint = '1;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(RspDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(RspDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + Pw'(1);
      2'b01:   cnt_d = cnt_q - Pw'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_q    <= 1'b0;
      infl_we_q <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      infl_q    <= acc;
      infl_we_q <= req_we_i;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Payload storage is deliberately not reset; rsp_valid_o qualifies it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q]  <= push_data;
      taint_q[wr_ptr_q] <= push_taint;
    end
  end

  assign rsp_valid_o       = (cnt_q != '0);
  assign rsp_rdata_o       = data_q[rd_ptr_q];
  assign rsp_rdata_taint_o = taint_q[rd_ptr_q];

`ifndef SYNTHESIS
  a_config_ok : assert property (@(posedge clk_i) disable iff (!rst_ni) ConfigOk)
    else $error("ift_sram_req_adapter: unsupported RspDepth/NumTaints");
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (cnt_q == Pw'(RspDepth))))
    else $error("ift_sram_req_adapter: response FIFO overflow");
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && (cnt_q == '0)))
    else $error("ift_sram_req_adapter: response FIFO underflow");
`endif

endmodule

// File: tb/tb_ift_sram_req_adapter.sv
// Self-checking bench for ift_sram_req_adapter: behavioural SRAM plus a response scoreboard.
module tb_ift_sram_req_adapter;

  localparam int unsigned Width      = 64;
  localparam int unsigned Aw         = 8;
  localparam int unsigned NumTaints  = 1;
  localparam int unsigned RspDepth   = 2;
  localparam int unsigned WidthBytes = Width / 8;

  logic                                 clk;
  logic                                 rst_n;
  logic                                 req_valid;
  logic                                 req_ready;
  logic                                 req_we;
  logic [Aw-1:0]                        req_addr;
  logic [Width-1:0]                     req_wdata;
  logic [WidthBytes-1:0]                req_be;
  logic [NumTaints-1:0]                 req_valid_taint;
  logic [NumTaints-1:0]                 req_we_taint;
  logic [NumTaints-1:0][Aw-1:0]         req_addr_taint;
  logic [NumTaints-1:0][Width-1:0]      req_wdata_taint;
  logic [NumTaints-1:0][WidthBytes-1:0] req_be_taint;
  logic                                 rsp_valid;
  logic                                 rsp_ready;
  logic [Width-1:0]                     rsp_rdata;
  logic [NumTaints-1:0][Width-1:0]      rsp_rdata_taint;
  logic                                 sram_req;
  logic                                 sram_write;
  logic [Aw-1:0]                        sram_addr;
  logic [Width-1:0]                     sram_wdata;
  logic [WidthBytes-1:0]                sram_wmask;
  logic [NumTaints-1:0]                 sram_req_taint;
  logic [NumTaints-1:0]                 sram_write_taint;
  logic [NumTaints-1:0][Aw-1:0]         sram_addr_taint;
  logic [NumTaints-1:0][Width-1:0]      sram_wdata_taint;
  logic [NumTaints-1:0][WidthBytes-1:0] sram_wmask_taint;
  logic [Width-1:0]                     sram_rdata;
  logic [NumTaints-1:0][Width-1:0]      sram_rdata_taint;

  typedef struct packed {
    logic [Width-1:0] data;
    logic [Width-1:0] taint;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   acc_cnt  = 0;
  int   rsp_cnt  = 0;

  logic [Width-1:0] smem     [2**Aw];
  logic [Width-1:0] stmem    [2**Aw];
  logic [Width-1:0] ref_mem  [2**Aw];
  logic [Width-1:0] ref_tmem [2**Aw];

  ift_sram_req_adapter #(
    .Width     (Width),
    .Aw        (Aw),
    .NumTaints (NumTaints),
    .RspDepth  (RspDepth)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_we_i           (req_we),
    .req_addr_i         (req_addr),
    .req_wdata_i        (req_wdata),
    .req_be_i           (req_be),
    .req_valid_taint_i  (req_valid_taint),
    .req_we_taint_i     (req_we_taint),
    .req_addr_taint_i   (req_addr_taint),
    .req_wdata_taint_i  (req_wdata_taint),
    .req_be_taint_i     (req_be_taint),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_rdata_o        (rsp_rdata),
    .rsp_rdata_taint_o  (rsp_rdata_taint),
    .sram_req_o         (sram_req),
    .sram_write_o       (sram_write),
    .sram_addr_o        (sram_addr),
    .sram_wdata_o       (sram_wdata),
    .sram_wmask_o       (sram_wmask),
    .sram_req_taint_o   (sram_req_taint),
    .sram_write_taint_o (sram_write_taint),
    .sram_addr_taint_o  (sram_addr_taint),
    .sram_wdata_taint_o (sram_wdata_taint),
    .sram_wmask_taint_o (sram_wmask_taint),
    .sram_rdata_i       (sram_rdata),
    .sram_rdata_taint_i (sram_rdata_taint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle read latency, byte-masked writes of data and taint.
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_write) begin
        for (int b = 0; b < WidthBytes; b++) begin
          if (sram_wmask[b]) begin
            smem[sram_addr][b*8 +: 8]  <= sram_wdata[b*8 +: 8];
            stmem[sram_addr][b*8 +: 8] <= sram_wdata_taint[0][b*8 +: 8];
          end
        end
      end else begin
        sram_rdata          <= smem[sram_addr];
        sram_rdata_taint[0] <= stmem[sram_addr];
      end
    end
  end

  // Scoreboard: push on accepted request, pop on consumed response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        exp_t e;
        logic ctl;
        acc_cnt++;
        n_checks++;
        if (sram_req !== 1'b1 || sram_write !== req_we || sram_addr !== req_addr ||
            sram_wdata !== req_wdata || sram_wmask !== req_be ||
            sram_req_taint !== req_valid_taint || sram_write_taint !== req_we_taint ||
            sram_addr_taint !== req_addr_taint || sram_wdata_taint !== req_wdata_taint ||
            sram_wmask_taint !== req_be_taint) begin
          $display("FAIL sram_strobe_acc: got req=%b we=%b addr=%h wmask=%h required we=%b addr=%h be=%h",
                   sram_req, sram_write, sram_addr, sram_wmask, req_we, req_addr, req_be);
        end else begin
          n_pass++;
        end
        ctl = req_valid_taint[0] | req_we_taint[0] | (|req_addr_taint[0]) |
              (req_we & (|req_be_taint[0]));
        if (req_we) begin
          e.data  = '0;
          e.taint = '0;
          for (int b = 0; b < WidthBytes; b++) begin
            if (req_be[b]) begin
              ref_mem[req_addr][b*8 +: 8]  = req_wdata[b*8 +: 8];
              ref_tmem[req_addr][b*8 +: 8] = req_wdata_taint[0][b*8 +: 8];
            end
          end
        end else begin
          e.data  = ref_mem[req_addr];
          e.taint = ref_tmem[req_addr];
        end
`ifdef IFT_SRAM_ADAPTER_CTRL_TAINT_EN
        if (ctl) e.taint = '1;
`else
        ctl = 1'b0;
`endif
        sb.push_back(e);
      end else begin
        n_checks++;
        if (sram_req !== 1'b0 || sram_write !== 1'b0 || sram_addr !== '0 ||
            sram_wdata !== '0 || sram_wmask !== '0 || sram_req_taint !== '0 ||
            sram_write_taint !== '0 || sram_addr_taint !== '0 ||
            sram_wdata_taint !== '0 || sram_wmask_taint !== '0) begin
          $display("FAIL sram_strobe_idle: got req=%b addr=%h wdata=%h required all zero",
                   sram_req, sram_addr, sram_wdata);
        end else begin
          n_pass++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected_rsp: got rdata=%h required no response", rsp_rdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_rdata !== e.data || rsp_rdata_taint[0] !== e.taint) begin
            $display("FAIL sb_rsp: got rdata=%h taint=%h required rdata=%h taint=%h",
                     rsp_rdata, rsp_rdata_taint[0], e.data, e.taint);
          end else begin
            n_pass++;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [Aw-1:0] a, input logic [Width-1:0] d,
                         input logic [WidthBytes-1:0] be);
    req_valid       = 1'b1;
    req_we          = we;
    req_addr        = a;
    req_wdata       = d;
    req_be          = be;
    req_valid_taint = '0;
    req_we_taint    = '0;
    req_addr_taint  = '0;
    req_wdata_taint = '0;
    req_be_taint    = '0;
  endtask

  task automatic idle;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && (sb.size() != 0 || rsp_valid); i++) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle();
    set_req(1'b0, '0, '0, '0);
    idle();
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || sram_req !== 1'b0) begin
      $display("FAIL reset_idle: got valid=%b ready=%b sram_req=%b required 0 1 0",
               rsp_valid, req_ready, sram_req);
    end else begin
      n_pass++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read;
    rsp_ready = 1'b1;
    set_req(1'b1, 8'h10, 64'hDEADBEEF_00000000, 8'hFF);
    tick();
    set_req(1'b0, 8'h10, '0, '0);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL wr_lat_t1: got valid=%b required 0", rsp_valid);
    else n_pass++;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0) begin
      $display("FAIL wr_rsp_t2: got valid=%b rdata=%h required 1 0", rsp_valid, rsp_rdata);
    end else begin
      n_pass++;
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEADBEEF_00000000) begin
      $display("FAIL rd_rsp_t3: got valid=%b rdata=%h required 1 deadbeef00000000",
               rsp_valid, rsp_rdata);
    end else begin
      n_pass++;
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_done: got valid=%b required 0", rsp_valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure;
    int rsp0;
    rsp_ready = 1'b1;
    set_req(1'b1, 8'h11, 64'h1111_2222_3333_4444, 8'hFF);
    tick();
    set_req(1'b1, 8'h12, 64'h5555_6666_7777_8888, 8'h0F);
    tick();
    idle();
    drain();
    rsp0 = rsp_cnt;
    rsp_ready = 1'b0;
    set_req(1'b0, 8'h10, '0, '0);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL bp_ready_1st: got %b required 1", req_ready);
    else n_pass++;
    tick();
    set_req(1'b0, 8'h11, '0, '0);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL bp_ready_2nd: got %b required 1", req_ready);
    else n_pass++;
    tick();
    set_req(1'b0, 8'h12, '0, '0);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL bp_ready_3rd: got %b required 0", req_ready);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      $display("FAIL bp_full: got ready=%b valid=%b required 0 1", req_ready, rsp_valid);
    end else begin
      n_pass++;
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEADBEEF_00000000) begin
      $display("FAIL bp_release: got ready=%b valid=%b rdata=%h required 1 1 deadbeef00000000",
               req_ready, rsp_valid, rsp_rdata);
    end else begin
      n_pass++;
    end
    tick();
    idle();
    drain();
    n_checks++;
    if (rsp_cnt - rsp0 !== 3) $display("FAIL bp_rsp_count: got %0d required 3", rsp_cnt - rsp0);
    else n_pass++;
  endtask

  task automatic test_taint;
    logic [Width-1:0] exp2;
`ifdef IFT_SRAM_ADAPTER_CTRL_TAINT_EN
    exp2 = '1;
`else
    exp2 = 64'h00FF;
`endif
    rsp_ready = 1'b1;
    set_req(1'b1, 8'h20, 64'h0123_4567_89AB_CDEF, 8'hFF);
    req_wdata_taint[0] = 64'h00FF;
    tick();
    set_req(1'b0, 8'h20, '0, '0);
    tick();
    set_req(1'b0, 8'h20, '0, '0);
    req_addr_taint[0] = 8'h01;
    tick();
    idle();
    req_addr_taint = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata_taint[0] !== 64'h00FF) begin
      $display("FAIL taint_read: got valid=%b taint=%h required 1 00000000000000ff",
               rsp_valid, rsp_rdata_taint[0]);
    end else begin
      n_pass++;
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata_taint[0] !== exp2) begin
      $display("FAIL taint_addr: got valid=%b taint=%h required 1 %h",
               rsp_valid, rsp_rdata_taint[0], exp2);
    end else begin
      n_pass++;
    end
    tick();
    drain();
  endtask

  task automatic test_reset_inflight;
    rsp_ready = 1'b0;
    set_req(1'b0, 8'h11, '0, '0);
    tick();
    set_req(1'b0, 8'h12, '0, '0);
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1) $display("FAIL rst_pre_queued: got %b required 1", rsp_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || sram_req !== 1'b0) begin
      $display("FAIL rst_async: got valid=%b ready=%b sram_req=%b required 0 1 0",
               rsp_valid, req_ready, sram_req);
    end else begin
      n_pass++;
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        $display("FAIL rst_no_stale: cycle %0d got valid=%b ready=%b required 0 1",
                 i, rsp_valid, req_ready);
      end else begin
        n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int acc0;
    int rsp0;
    int low;
    acc0 = acc_cnt;
    rsp0 = rsp_cnt;
    low  = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_req(1'b0, Aw'($urandom_range(0, 2**Aw - 1)), '0, '0);
      @(negedge clk);
      if (req_ready !== 1'b1) low++;
      tick();
    end
    idle();
    drain();
    n_checks++;
    if (acc_cnt - acc0 !== 100) $display("FAIL b2b_accepts: got %0d required 100", acc_cnt - acc0);
    else n_pass++;
    n_checks++;
    if (rsp_cnt - rsp0 !== 100) $display("FAIL b2b_rsps: got %0d required 100", rsp_cnt - rsp0);
    else n_pass++;
    n_checks++;
    if (low !== 0) $display("FAIL b2b_ready_low: got %0d cycles required 0", low);
    else n_pass++;
  endtask

  task automatic test_final;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL sb_leftover: got %0d entries required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 2**Aw; i++) begin
      smem[i]     = '0;
      stmem[i]    = '0;
      ref_mem[i]  = '0;
      ref_tmem[i] = '0;
    end
    sram_rdata       = '0;
    sram_rdata_taint = '0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_taint();
    test_reset_inflight();
    test_back_to_back();
    test_final();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
